// File: rtl/sdi_stm_pkg.sv
// ============================================================================
//  sdi_stm_pkg
//  Shared types and defaults for the SDI ROI capture block.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package sdi_stm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DROP   = 2'd3
  } state_t;

  localparam int LINE_START_DEF = 42;
  localparam int LINE_END_DEF   = 1121;
  localparam int MAX_W_DEF      = 1920;

  // Control and config fields of one registered SDI word.
  typedef struct packed {
    logic        trs;
    logic        sav;
    logic        eav;
    logic [10:0] line;
    logic        enable;
    logic        dec_x;
    logic [15:0] w;
    logic [15:0] h;
    logic [15:0] ox;
    logic [15:0] oy;
  } rx_word_t;

  function automatic int calc_tdw(input int cw);
    return ((2 * cw + 7) / 8) * 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdi_stm_fifo.sv
// ============================================================================
//  sdi_stm_fifo
//  Synchronous first-word-fall-through FIFO; a write at full is refused.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sdi_stm_fifo #(
  parameter int W  = 18,
  parameter int AW = 9
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int DEPTH = 1 << AW;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          w_wr_go, w_rd_go;

  // Full/empty come from the registered count, so a same-cycle read never
  // frees space for a write.
  always_comb begin
    o_full   = cnt_q[AW];
    o_empty  = (cnt_q == '0);
    w_wr_go  = i_wr_en && !o_full;
    w_rd_go  = i_rd_en && !o_empty;
    wr_ptr_d = w_wr_go ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = w_rd_go ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (w_wr_go && !w_rd_go) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (!w_wr_go && w_rd_go) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
    o_rd_data = mem_q[rd_ptr_q];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_wr_go) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sdi_roi_stm.sv
// ============================================================================
//  sdi_roi_stm
//  SDI 4:2:2 capture: TRS parsing, ROI crop, 2:1 decimation, AXI4-Stream out.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sdi_roi_stm
  import sdi_stm_pkg::*;
#(
  parameter int CW         = 8,
  parameter int TDW        = calc_tdw(CW),
  parameter int FIFO_AW    = 9,
  parameter int LINE_START = LINE_START_DEF,
  parameter int LINE_END   = LINE_END_DEF,
  parameter int MAX_W      = MAX_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [9:0]       i_rx_ds1a,
  input  logic [9:0]       i_rx_ds2a,
  input  logic             i_rx_trs,
  input  logic             i_rx_sav,
  input  logic             i_rx_eav,
  input  logic [10:0]      i_rx_line_number,
  input  logic             i_enable,
  input  logic             i_dec_x,
  input  logic [15:0]      i_image_w,
  input  logic [15:0]      i_image_h,
  input  logic [15:0]      i_offset_x,
  input  logic [15:0]      i_offset_y,
  output logic [TDW-1:0]   m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  output logic [TDW/8-1:0] m_axis_tkeep,
  input  logic             m_axis_tready,
  output logic [15:0]      o_frame_cnt,
  output logic [15:0]      o_drop_cnt,
  output logic             o_cfg_err
);

  localparam int          FW        = TDW + 2;
  localparam logic [16:0] ACT_LINES = 17'(LINE_END - LINE_START + 1);

  rx_word_t        s0_d, s0_q;
  logic [2*CW-1:0] s0_pix_d, s0_pix_q;

  state_t          state_d, state_q;
  logic [15:0]     cfg_w_d, cfg_w_q, cfg_h_d, cfg_h_q;
  logic [15:0]     cfg_ox_d, cfg_ox_q, cfg_oy_d, cfg_oy_q;
  logic            cfg_dec_d, cfg_dec_q;
  logic [15:0]     line_cnt_d, line_cnt_q, pix_cnt_d, pix_cnt_q;
  logic            sof_pend_d, sof_pend_q;
  logic            wr_en_d, wr_en_q;
  logic [FW-1:0]   wr_beat_d, wr_beat_q;
  logic [15:0]     frame_cnt_d, frame_cnt_q, drop_cnt_d, drop_cnt_q;
  logic            cfg_err_d, cfg_err_q;

  logic            w_is_sav, w_frame_end, w_latch_pt, w_new_bad;
  logic [16:0]     w_new_ox_w, w_new_oy_h, w_cfg_ox_w, w_cfg_oy_h, w_last_pix;
  logic            w_line_in, w_pix_in, w_pix_odd, w_keep, w_tuser, w_tlast;
  logic            w_wr_req, w_ovf;
  logic            ev_latch, ev_cfg_bad, ev_frame_done, ev_drop;
  logic            fifo_full, fifo_empty;
  logic [FW-1:0]   fifo_rd_data;

  generate
    if (CW < 10) begin : g_lsb_discard
      logic unused_lsb;
      assign unused_lsb = ^{i_rx_ds1a[9-CW:0], i_rx_ds2a[9-CW:0]};
    end
  endgenerate

  always_comb begin
    s0_d        = '0;
    s0_d.trs    = i_rx_trs;
    s0_d.sav    = i_rx_sav;
    s0_d.eav    = i_rx_eav;
    s0_d.line   = i_rx_line_number;
    s0_d.enable = i_enable;
    s0_d.dec_x  = i_dec_x;
    s0_d.w      = i_image_w;
    s0_d.h      = i_image_h;
    s0_d.ox     = i_offset_x;
    s0_d.oy     = i_offset_y;
    s0_pix_d    = {i_rx_ds2a[9 -: CW], i_rx_ds1a[9 -: CW]};
  end

  // Word decode, config validation and the write-stage overflow check.
  always_comb begin
    w_is_sav    = s0_q.trs && s0_q.sav;
    w_frame_end = s0_q.trs && s0_q.eav && (s0_q.line == 11'(LINE_END));
    w_latch_pt  = w_is_sav && (s0_q.line == 11'(LINE_START));
    w_new_ox_w  = {1'b0, s0_q.ox} + {1'b0, s0_q.w};
    w_new_oy_h  = {1'b0, s0_q.oy} + {1'b0, s0_q.h};
    w_new_bad   = (s0_q.w == 16'd0) || (s0_q.h == 16'd0) ||
                  (w_new_ox_w > 17'(MAX_W)) || (w_new_oy_h > ACT_LINES);
    w_wr_req    = wr_en_q && (state_q == ST_ACTIVE);
    w_ovf       = w_wr_req && fifo_full;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ev_latch      = 1'b0;
    ev_cfg_bad    = 1'b0;
    ev_frame_done = 1'b0;
    ev_drop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s0_q.enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!s0_q.enable) begin
          state_d = ST_IDLE;
        end else if (w_latch_pt) begin
          ev_latch   = 1'b1;
          ev_cfg_bad = w_new_bad;
          ev_drop    = w_new_bad;
          state_d    = w_new_bad ? ST_DROP : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_frame_end) begin
          state_d       = s0_q.enable ? ST_ARM : ST_IDLE;
          ev_frame_done = !w_ovf;
          ev_drop       = w_ovf;
        end else if (w_ovf) begin
          state_d = ST_DROP;
          ev_drop = 1'b1;
        end
      end
      ST_DROP: begin
        if (w_frame_end) state_d = s0_q.enable ? ST_ARM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_cnt_d = ev_frame_done ? frame_cnt_q + 16'd1 : frame_cnt_q;
    drop_cnt_d  = ev_drop ? drop_cnt_q + 16'd1 : drop_cnt_q;
    cfg_err_d   = ev_latch ? ev_cfg_bad : cfg_err_q;
    o_frame_cnt = frame_cnt_q;
    o_drop_cnt  = drop_cnt_q;
    o_cfg_err   = cfg_err_q;
  end

  // Shadow config, line/pixel counters and the keep decision for each word.
  always_comb begin
    cfg_w_d   = ev_latch ? s0_q.w     : cfg_w_q;
    cfg_h_d   = ev_latch ? s0_q.h     : cfg_h_q;
    cfg_ox_d  = ev_latch ? s0_q.ox    : cfg_ox_q;
    cfg_oy_d  = ev_latch ? s0_q.oy    : cfg_oy_q;
    cfg_dec_d = ev_latch ? s0_q.dec_x : cfg_dec_q;

    line_cnt_d = line_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    if (ev_latch) begin
      line_cnt_d = 16'd1;
      pix_cnt_d  = 16'd0;
    end else if (w_is_sav) begin
      if (line_cnt_q != 16'hFFFF) line_cnt_d = line_cnt_q + 16'd1;
      pix_cnt_d = 16'd0;
    end else if (!s0_q.trs && (pix_cnt_q != 16'hFFFF)) begin
      pix_cnt_d = pix_cnt_q + 16'd1;
    end

    w_cfg_ox_w = {1'b0, cfg_ox_q} + {1'b0, cfg_w_q};
    w_cfg_oy_h = {1'b0, cfg_oy_q} + {1'b0, cfg_h_q};
    w_line_in  = ({1'b0, line_cnt_q} > {1'b0, cfg_oy_q}) &&
                 ({1'b0, line_cnt_q} <= w_cfg_oy_h);
    w_pix_in   = ({1'b0, pix_cnt_d} > {1'b0, cfg_ox_q}) &&
                 ({1'b0, pix_cnt_d} <= w_cfg_ox_w);
    w_pix_odd  = pix_cnt_d[0] ^ cfg_ox_q[0];
    w_keep     = (state_q == ST_ACTIVE) && !s0_q.trs && w_line_in && w_pix_in &&
                 (!cfg_dec_q || w_pix_odd);
    // With decimation and an even width the last kept pixel is one short.
    w_last_pix = w_cfg_ox_w - 17'(cfg_dec_q & ~cfg_w_q[0]);
    w_tlast    = w_keep && ({1'b0, pix_cnt_d} == w_last_pix);
    w_tuser    = w_keep && sof_pend_q;

    sof_pend_d = ev_latch ? 1'b1 : (w_keep ? 1'b0 : sof_pend_q);
    wr_en_d    = w_keep;
    wr_beat_d  = {w_tuser, w_tlast, TDW'(s0_pix_q)};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s0_q        <= '0;
      s0_pix_q    <= '0;
      cfg_w_q     <= '0;
      cfg_h_q     <= '0;
      cfg_ox_q    <= '0;
      cfg_oy_q    <= '0;
      cfg_dec_q   <= 1'b0;
      line_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      sof_pend_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_beat_q   <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      s0_q        <= s0_d;
      s0_pix_q    <= s0_pix_d;
      cfg_w_q     <= cfg_w_d;
      cfg_h_q     <= cfg_h_d;
      cfg_ox_q    <= cfg_ox_d;
      cfg_oy_q    <= cfg_oy_d;
      cfg_dec_q   <= cfg_dec_d;
      line_cnt_q  <= line_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      sof_pend_q  <= sof_pend_d;
      wr_en_q     <= wr_en_d;
      wr_beat_q   <= wr_beat_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  sdi_stm_fifo #(
    .W  (FW),
    .AW (FIFO_AW)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (w_wr_req),
    .i_wr_data (wr_beat_q),
    .i_rd_en   (m_axis_tready),
    .o_rd_data (fifo_rd_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  always_comb begin
    m_axis_tvalid = !fifo_empty;
    m_axis_tdata  = fifo_empty ? '0 : fifo_rd_data[TDW-1:0];
    m_axis_tlast  = !fifo_empty && fifo_rd_data[TDW];
    m_axis_tuser  = !fifo_empty && fifo_rd_data[TDW+1];
    m_axis_tkeep  = '1;
  end

endmodule

`default_nettype wire
